// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage and instruction memory.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, timed-out imem handshake, fetch buffer and IF/ID register.
// Optional FETCH_PERF_EN adds a saturating count of valid commits on fetch_count.
module fetch_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned      TIMEOUT   = 16,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fetch_start,
  input  logic             flush,
  input  logic             pc_wren,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  fetch_unit_if.master     imem,
  input  logic             if_id_wren,
  output logic             fetch_valid,
  output logic             fetch_err,
  output logic [31:0]      if_id_instr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic             if_id_valid,
  output logic [XLEN-1:0]  pc,
  output logic             misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      fetch_count
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     buf_q, buf_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic            commit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      buf_q      <= NOP_INSTR;
      err_q      <= 1'b0;
      addr_q     <= '0;
      instr_q    <= NOP_INSTR;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      pc_q       <= RESET_PC;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    err_d         = err_q;
    addr_d        = addr_q;
    instr_d       = instr_q;
    id_pc_d       = id_pc_q;
    id_valid_d    = id_valid_q;
    commit        = 1'b0;
    imem.imem_req = 1'b0;
    fetch_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fetch_start) begin
          addr_d  = pc_q;
          state_d = StReq;
        end
      end
      StReq: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          buf_d   = imem.imem_rdata;
          err_d   = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d   = CntW'(1);
          state_d = StWait;
        end
      end
      StWait: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          buf_d   = imem.imem_rdata;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          buf_d   = NOP_INSTR;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        fetch_valid = 1'b1;
        if (if_id_wren) begin
          commit     = 1'b1;
          instr_d    = buf_q;
          id_pc_d    = addr_q;
          id_valid_d = !err_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over any same-cycle start, capture or commit.
    if (flush) begin
      state_d    = StIdle;
      cnt_d      = '0;
      buf_d      = buf_q;
      err_d      = err_q;
      addr_d     = addr_q;
      instr_d    = instr_q;
      id_pc_d    = id_pc_q;
      id_valid_d = id_valid_q;
      commit     = 1'b0;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    mis_d = mis_q;
    if (pc_wren) begin
      if (branch_taken) begin
        pc_d = {branch_target[XLEN-1:2], 2'b00};
        if (branch_target[1:0] != 2'b00) begin
          mis_d = 1'b1;
        end
      end else begin
        pc_d = pc_q + XLEN'(4);
      end
    end
  end

  assign imem.imem_addr = addr_q;
  assign fetch_err      = err_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_valid    = id_valid_q;
  assign pc             = pc_q;
  assign misalign_err   = mis_q;

`ifdef FETCH_PERF_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (commit && !err_q && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch-latency and PC-update tables plus flush/reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_start;
  logic        flush;
  logic        pc_wren;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_wren;
  logic        fetch_valid;
  logic        fetch_err;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic [31:0] pc;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_unit_if #(.XLEN(32)) imem_bus ();

  fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_start   (fetch_start),
    .flush         (flush),
    .pc_wren       (pc_wren),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .if_id_wren    (if_id_wren),
    .fetch_valid   (fetch_valid),
    .fetch_err     (fetch_err),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .pc            (pc),
    .misalign_err  (misalign_err)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;       // cycles of imem_req before imem_ready; -1 = never
    logic [31:0] word;
    int          exp_req;
    logic        exp_err;
    logic [31:0] exp_instr;
    logic        exp_valid;
  } fetch_vec_t;

  typedef struct {
    logic        wren;
    logic        taken;
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } pc_vec_t;

  fetch_vec_t fvec[4];
  pc_vec_t    pvec[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"}, 64'(pc), 64'h0);
    chk({tag, "_req"}, 64'(imem_bus.imem_req), 64'h0);
    chk({tag, "_addr"}, 64'(imem_bus.imem_addr), 64'h0);
    chk({tag, "_fvalid"}, 64'(fetch_valid), 64'h0);
    chk({tag, "_ferr"}, 64'(fetch_err), 64'h0);
    chk({tag, "_instr"}, 64'(if_id_instr), 64'h13);
    chk({tag, "_idpc"}, 64'(if_id_pc), 64'h0);
    chk({tag, "_idvalid"}, 64'(if_id_valid), 64'h0);
    chk({tag, "_mis"}, 64'(misalign_err), 64'h0);
  endtask

  int req_cycles;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fvec[0] = '{0,  32'h0050_0093, 1,  1'b0, 32'h0050_0093, 1'b1};
    fvec[1] = '{3,  32'h00a0_0113, 4,  1'b0, 32'h00a0_0113, 1'b1};
    fvec[2] = '{-1, 32'hdead_beef, 16, 1'b1, 32'h0000_0013, 1'b0};
    fvec[3] = '{1,  32'h0020_81b3, 2,  1'b0, 32'h0020_81b3, 1'b1};

    pvec[0] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    pvec[1] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    pvec[2] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
    pvec[3] = '{1'b1, 1'b1, 32'h0000_0102, 32'h0000_0100, 1'b1};
    pvec[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0104, 1'b1};
    pvec[5] = '{1'b1, 1'b1, 32'h0000_0200, 32'h0000_0200, 1'b1};
    pvec[6] = '{1'b0, 1'b1, 32'h0000_0333, 32'h0000_0200, 1'b1};

    reset_n             = 1'b0;
    fetch_start         = 1'b0;
    flush               = 1'b0;
    pc_wren             = 1'b0;
    branch_taken        = 1'b0;
    branch_target       = '0;
    if_id_wren          = 1'b0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Fetch table: each entry fetches at pc=4*i, commits, then bumps the PC.
    for (int i = 0; i < 4; i++) begin
      imem_bus.imem_rdata = fvec[i].word;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      chk($sformatf("f%0d_req_first", i), 64'(imem_bus.imem_req), 64'h1);
      chk($sformatf("f%0d_addr", i), 64'(imem_bus.imem_addr), 64'(4 * i));
      req_cycles = 0;
      while (imem_bus.imem_req && req_cycles < 40) begin
        imem_bus.imem_ready = (fvec[i].lat >= 0) && (req_cycles == fvec[i].lat);
        req_cycles++;
        tick();
      end
      imem_bus.imem_ready = 1'b0;
      chk($sformatf("f%0d_req_cycles", i), 64'(req_cycles), 64'(fvec[i].exp_req));
      chk($sformatf("f%0d_fvalid", i), 64'(fetch_valid), 64'h1);
      chk($sformatf("f%0d_ferr", i), 64'(fetch_err), 64'(fvec[i].exp_err));
      if_id_wren = 1'b1;
      tick();
      if_id_wren = 1'b0;
      chk($sformatf("f%0d_instr", i), 64'(if_id_instr), 64'(fvec[i].exp_instr));
      chk($sformatf("f%0d_idpc", i), 64'(if_id_pc), 64'(4 * i));
      chk($sformatf("f%0d_idvalid", i), 64'(if_id_valid), 64'(fvec[i].exp_valid));
      chk($sformatf("f%0d_idle", i), 64'(fetch_valid), 64'h0);
      pc_wren = 1'b1;
      tick();
      pc_wren = 1'b0;
    end

    // Flush in the same cycle as imem_ready: no capture, back to idle.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'h1111_1111;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    imem_bus.imem_ready = 1'b0;
    chk("flush_fvalid", 64'(fetch_valid), 64'h0);
    chk("flush_req", 64'(imem_bus.imem_req), 64'h0);
    if_id_wren = 1'b1;
    tick();
    if_id_wren = 1'b0;
    chk("flush_instr_kept", 64'(if_id_instr), 64'h0020_81b3);
    chk("flush_fvalid_after", 64'(fetch_valid), 64'h0);

    // pc_wren together with fetch_start: request uses the old PC.
    imem_bus.imem_rdata = 32'h00c0_0193;
    fetch_start = 1'b1;
    pc_wren     = 1'b1;
    tick();
    fetch_start = 1'b0;
    pc_wren     = 1'b0;
    chk("pcfs_addr", 64'(imem_bus.imem_addr), 64'h10);
    chk("pcfs_pc", 64'(pc), 64'h14);
    imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_ready = 1'b0;
    chk("pcfs_fvalid", 64'(fetch_valid), 64'h1);
    if_id_wren = 1'b1;
    tick();
    if_id_wren = 1'b0;
    chk("pcfs_idpc", 64'(if_id_pc), 64'h10);
    chk("pcfs_instr", 64'(if_id_instr), 64'h00c0_0193);
`ifdef FETCH_PERF_EN
    chk("perf_count", 64'(fetch_count), 64'h4);
`endif

    // PC update table.
    for (int i = 0; i < 7; i++) begin
      pc_wren       = pvec[i].wren;
      branch_taken  = pvec[i].taken;
      branch_target = pvec[i].target;
      tick();
      pc_wren      = 1'b0;
      branch_taken = 1'b0;
      chk($sformatf("p%0d_pc", i), 64'(pc), 64'(pvec[i].exp_pc));
      chk($sformatf("p%0d_mis", i), 64'(misalign_err), 64'(pvec[i].exp_mis));
    end

    // Reset while waiting on memory; a late imem_ready must be ignored.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    tick();
    chk("rst_mid_req_before", 64'(imem_bus.imem_req), 64'h1);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("rst_mid");
    reset_n = 1'b1;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'h0bad_0bad;
    tick();
    tick();
    tick();
    imem_bus.imem_ready = 1'b0;
    chk("rst_late_fvalid", 64'(fetch_valid), 64'h0);
    chk("rst_late_req", 64'(imem_bus.imem_req), 64'h0);
    chk("rst_late_ferr", 64'(fetch_err), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
